// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with flush, timeout and optional misalign trap (FETCH_MISALIGN_TRAP_EN)
module instr_fetch_unit #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req_valid,
    output logic        fetch_req_ready,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        fetch_busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  out_fault
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state, state_n;
    logic            drop, drop_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [31:0]     pc_q, pc_n, instr_q, instr_n;
    logic [1:0]      fault_q, fault_n;
    logic            misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = |fetch_pc[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign fetch_req_ready = state == IDLE && !drop && !flush;
    assign fetch_busy      = state != IDLE || drop;
    assign mem_req_valid   = state == REQ;
    assign mem_req_addr    = {pc_q[31:2], 2'b00};
    assign out_valid       = state == HOLD;
    assign out_instr       = instr_q;
    assign out_pc          = pc_q;
    assign out_fault       = fault_q;

    // next-state: fetch sequencing, flush abandonment, timeout and stale-response tracking
    always_comb begin
        state_n = state;
        drop_n  = drop;
        cnt_n   = cnt;
        pc_n    = pc_q;
        instr_n = instr_q;
        fault_n = fault_q;
        if (drop && mem_resp_valid && state != WAIT) drop_n = 1'b0;
        case (state)
            IDLE: if (fetch_req_valid && fetch_req_ready) begin
                pc_n    = fetch_pc;
                instr_n = NOP_INSTR;
                state_n = misalign ? HOLD : REQ;
                fault_n = misalign ? 2'd1 : 2'd0;
            end
            REQ: if (flush) begin
                state_n = IDLE;
                if (mem_req_ready) drop_n = 1'b1;
            end else if (mem_req_ready) begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: if (flush) begin
                state_n = IDLE;
                if (!mem_resp_valid) drop_n = 1'b1;
            end else if (mem_resp_valid) begin
                state_n = HOLD;
                instr_n = mem_resp_data;
                fault_n = 2'd0;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state_n = HOLD;
                instr_n = NOP_INSTR;
                fault_n = 2'd2;
                drop_n  = 1'b1;
            end else begin
                cnt_n = cnt + CW'(1);
            end
            HOLD: if (flush || out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            drop    <= 1'b0;
            cnt     <= '0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            fault_q <= 2'd0;
        end else begin
            state   <= state_n;
            drop    <= drop_n;
            cnt     <= cnt_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            fault_q <= fault_n;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven per-cycle vectors plus reset sequences for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam logic [31:0] N = 32'h00000013;

    logic        clock = 0, reset = 1;
    logic        fetch_req_valid = 0, fetch_req_ready, flush = 0, fetch_busy;
    logic [31:0] fetch_pc = 0;
    logic        mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0;
    logic [31:0] mem_req_addr, mem_resp_data = 0;
    logic        out_valid, out_ready = 0;
    logic [31:0] out_instr, out_pc;
    logic [1:0]  out_fault;

    int nvec = 0, nbad = 0;

    instr_fetch_unit dut (
        .clock(clock), .reset(reset),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_pc(fetch_pc), .flush(flush), .fetch_busy(fetch_busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_fault(out_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic fv; logic [31:0] pc; logic fl, mrdy, rv; logic [31:0] rd; logic ordy;
        logic frdy, busy, mreq; logic [31:0] addr; logic ov;
        logic [31:0] instr, opc; logic [1:0] flt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(logic fv, logic [31:0] pc, logic fl, logic mrdy, logic rv,
                               logic [31:0] rd, logic ordy, logic frdy, logic busy, logic mreq,
                               logic [31:0] addr, logic ov, logic [31:0] instr,
                               logic [31:0] opc, logic [1:0] flt);
        vec_t r;
        r.fv = fv; r.pc = pc; r.fl = fl; r.mrdy = mrdy; r.rv = rv; r.rd = rd; r.ordy = ordy;
        r.frdy = frdy; r.busy = busy; r.mreq = mreq; r.addr = addr; r.ov = ov;
        r.instr = instr; r.opc = opc; r.flt = flt;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // drive one cycle of inputs, check that cycle's outputs, then advance past the edge
    task automatic apply(vec_t r, string tag);
        fetch_req_valid = r.fv; fetch_pc = r.pc; flush = r.fl; mem_req_ready = r.mrdy;
        mem_resp_valid = r.rv; mem_resp_data = r.rd; out_ready = r.ordy;
        #1;
        chk({tag, " fetch_req_ready"}, 32'(fetch_req_ready), 32'(r.frdy));
        chk({tag, " fetch_busy"}, 32'(fetch_busy), 32'(r.busy));
        chk({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'(r.mreq));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(r.ov));
        if (r.mreq) chk({tag, " mem_req_addr"}, mem_req_addr, r.addr);
        if (r.ov) begin
            chk({tag, " out_instr"}, out_instr, r.instr);
            chk({tag, " out_pc"}, out_pc, r.opc);
            chk({tag, " out_fault"}, 32'(out_fault), 32'(r.flt));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        // basic fetch, immediate ready, response in first WAIT cycle
        tv.push_back(v(1,'h100,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h100, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'hDEADBEEF,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,1, 0,1,0,0, 1,'hDEADBEEF,'h100,0));
        // memory not ready for 3 cycles, address held
        tv.push_back(v(1,'h100,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        for (int i = 0; i < 3; i++) tv.push_back(v(0,0,0,0,0,0,0, 0,1,1,'h100, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h100, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'h12345678,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,1, 0,1,0,0, 1,'h12345678,'h100,0));
        // timeout after exactly 16 WAIT cycles, late response dropped
        tv.push_back(v(1,'h108,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h108, 0,0,0,0));
        for (int i = 0; i < 16; i++) tv.push_back(v(0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 0,1,0,0, 1,N,'h108,2));
        tv.push_back(v(0,0,0,0,0,0,1, 0,1,0,0, 1,N,'h108,2));
        tv.push_back(v(1,'h300,0,0,1,'hAAAAAAAA,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        // flush in WAIT, response two cycles later discarded, then fetch 0x200
        tv.push_back(v(1,'h10C,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h10C, 0,0,0,0));
        tv.push_back(v(0,0,1,0,0,0,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'hBAD0BAD0,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(1,'h200,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h200, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'h00500093,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,1, 0,1,0,0, 1,'h00500093,'h200,0));
        // HOLD stalled 4 cycles, then flush with out_ready low
        tv.push_back(v(1,'h204,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h204, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'hCAFEF00D,0, 0,1,0,0, 0,0,0,0));
        for (int i = 0; i < 4; i++) tv.push_back(v(0,0,0,0,0,0,0, 0,1,0,0, 1,'hCAFEF00D,'h204,0));
        tv.push_back(v(0,0,1,0,0,0,0, 0,1,0,0, 1,'hCAFEF00D,'h204,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        // flush in REQ without memory ready: clean withdraw
        tv.push_back(v(1,'h208,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,1,0,0,0,0, 0,1,1,'h208, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        // flush in REQ with memory ready: response owed and dropped
        tv.push_back(v(1,'h20C,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,1,1,0,0,0, 0,1,1,'h20C, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'h00000001,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        // flush in WAIT with same-cycle response: nothing owed
        tv.push_back(v(1,'h210,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h210, 0,0,0,0));
        tv.push_back(v(0,0,1,0,1,'h00000077,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
        // flush in IDLE blocks accept; stray response in IDLE ignored
        tv.push_back(v(1,'h214,1,0,0,0,0, 0,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'h00000055,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
`ifdef FETCH_MISALIGN_TRAP_EN
        tv.push_back(v(1,'h102,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,1, 0,1,0,0, 1,N,'h102,1));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
`else
        tv.push_back(v(1,'h102,0,1,0,0,0, 1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,1,0,0,0, 0,1,1,'h100, 0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'h11111111,0, 0,1,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,1, 0,1,0,0, 1,'h11111111,'h102,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0));
`endif

        repeat (3) @(posedge clock);
        #1;
        chk("rst fetch_req_ready", 32'(fetch_req_ready), 32'd1);
        chk("rst fetch_busy", 32'(fetch_busy), 32'd0);
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst mem_req_addr", mem_req_addr, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_instr", out_instr, N);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_fault", 32'(out_fault), 32'd0);
        reset = 0;

        foreach (tv[i]) apply(tv[i], $sformatf("row%0d", i));

        // reset while holding an instruction
        apply(v(1,'h220,0,1,0,0,0, 1,0,0,0, 0,0,0,0), "hs1a");
        apply(v(0,0,0,1,0,0,0, 0,1,1,'h220, 0,0,0,0), "hs1b");
        apply(v(0,0,0,0,1,'h00000099,0, 0,1,0,0, 0,0,0,0), "hs1c");
        reset = 1;
        apply(v(0,0,0,0,0,0,0, 0,1,0,0, 1,'h00000099,'h220,0), "hs1d");
        reset = 0;
        chk("hs1 out_valid", 32'(out_valid), 32'd0);
        chk("hs1 out_instr", out_instr, N);
        chk("hs1 out_pc", out_pc, 32'd0);
        // reset clears a pending drop
        apply(v(1,'h224,0,1,0,0,0, 1,0,0,0, 0,0,0,0), "hs2a");
        apply(v(0,0,1,1,0,0,0, 0,1,1,'h224, 0,0,0,0), "hs2b");
        reset = 1;
        apply(v(0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0), "hs2c");
        reset = 0;
        apply(v(0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0), "hs2d");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end: takes the current program counter, issues a single-outstanding read to instruction memory over a valid/ready request channel, and returns the fetched word to decode through a valid/ready output stage. It sits between the program counter register and the decoder. Its `fetch_busy` output drives the PC's halt/stall input, so the PC advances only after the current fetch completes. It also handles pipeline flushes on branch or jump, response timeouts, and an optional misalignment trap.

## Interface
- TIMEOUT_CYCLES, 16, WAIT cycles allowed before timeout fault (≥2)
- NOP_INSTR, 32'h00000013, word substituted on any fault
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fetch_req_valid  in  1  PC value presented for fetch
- fetch_req_ready  out  1  fetch accepted this cycle
- fetch_pc  in  32  address to fetch
- flush  in  1  abandon current fetch (branch taken / jal / jalr)
- fetch_busy  out  1  state != IDLE or drop_pending; drives PC stall
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word address, {pc[31:2],2'b00}
- mem_resp_valid  in  1  read data valid (one cycle per accepted request)
- mem_resp_data  in  32  read data
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes
- out_instr  out  32  instruction word
- out_pc  out  32  PC of out_instr
- out_fault  out  2  0 none, 1 misaligned, 2 timeout

## Operation
- States: IDLE, REQ, WAIT, HOLD. Extra flag drop_pending marks one in-flight response that must be discarded.
- Reset: state IDLE, drop_pending=0, timeout counter=0. Outputs: mem_req_valid=0, out_valid=0, out_fault=0, out_instr=NOP_INSTR, out_pc=0, mem_req_addr=0, fetch_busy=0.
- fetch_req_ready = (state==IDLE) & !drop_pending & !flush.
- IDLE:
  - On accept, latch fetch_pc, go to REQ.
  - Under misalign trap with fetch_pc[1:0]!=0: go directly to HOLD, fault=1, instr=NOP_INSTR.
- REQ:
  - mem_req_valid=1 and mem_req_addr held stable until mem_req_ready.
  - On ready, go to WAIT and clear the counter.
- WAIT:
  - mem_resp_valid: latch data, go to HOLD, fault=0.
  - Otherwise the counter increments. At count==TIMEOUT_CYCLES-1 with no response: go to HOLD, fault=2, instr=NOP_INSTR, set drop_pending.
- HOLD: out_valid=1, outputs stable until out_ready, then go to IDLE.
- drop_pending: cleared when mem_resp_valid is seen outside WAIT. That response is discarded and never reaches out_*.
- Flush:
  - IDLE: request not accepted.
  - REQ without mem_req_ready: go to IDLE, request withdrawn.
  - REQ with mem_req_ready: go to IDLE, set drop_pending.
  - WAIT without response: go to IDLE, set drop_pending.
  - WAIT with mem_resp_valid in the same cycle: response discarded, go to IDLE, drop_pending unchanged.
  - HOLD: go to IDLE, out_valid drops next cycle even if out_ready was high.

## Timing
- Accept at edge N. REQ in cycle N+1. With immediate mem_req_ready, WAIT in N+2.
- A response in N+2 gives out_valid in N+3. Minimum request-to-output latency is 3 cycles; throughput is one instruction per ≥4 cycles.
- All outputs are registered or decoded from registered state. No combinational path from mem_resp_* to out_*.
- mem_resp_valid is ignored in IDLE, REQ and HOLD unless drop_pending=1.
- Reset mid-operation returns to IDLE immediately and clears drop_pending. Memory must be reset in the same cycle.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a misaligned fetch_pc skips memory entirely and produces fault=1, NOP_INSTR, with out_valid 1 cycle after accept.
- FETCH_MISALIGN_TRAP_EN undefined: low two bits are ignored, a normal fetch proceeds, and out_fault never equals 1.

## Test plan
- Reset, then fetch_pc=0x100, mem ready immediately, resp 0xDEADBEEF one cycle after acceptance -> out_valid at N+3, out_instr=0xDEADBEEF, out_pc=0x100, fault=0.
- mem_req_ready low 3 cycles -> mem_req_addr held 0x100 throughout; out_valid at N+6.
- No response for 16 WAIT cycles -> fault=2, out_instr=0x00000013. Late resp is dropped, after which fetch_req_ready rises.
- flush in WAIT, resp arrives 2 cycles later -> no out_valid, resp discarded. Next fetch 0x200 returns correct data.
- out_ready low 4 cycles in HOLD -> out_instr and out_pc stable. A flush during HOLD -> out_valid=0 next cycle.
- With FETCH_MISALIGN_TRAP_EN, fetch_pc=0x102 -> no mem_req_valid, fault=1, out_pc=0x102. Without it -> mem_req_addr=0x100.
